// File: rtl/life_step_engine_if.sv
// Selector-port bundle of the grid store: step control/status plus the row read/write bus.
// master = step engine, slave = grid store / top level.
interface life_step_engine_if #(
  parameter int ADDR_W = 2,
  parameter int COLS   = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic [15:0]       gen_count;
  logic              stable;
  logic              extinct;
  logic [ADDR_W-1:0] mem_sel;
  logic [COLS-1:0]   mem_rd_data;
  logic              mem_wr_en;
  logic [COLS-1:0]   mem_wr_data;

  modport master (
    input  start, mem_rd_data,
    output busy, done, gen_count, stable, extinct, mem_sel, mem_wr_en, mem_wr_data
  );

  modport slave (
    output start, mem_rd_data,
    input  busy, done, gen_count, stable, extinct, mem_sel, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/life_step_engine.sv
// Game of Life generation step on a toroidal grid: buffers all rows, then writes the next generation back.
// done is seen 2*ROWS+2 cycles after the start-sampling edge; start is ignored while busy.
module life_step_engine #(
  parameter int ROWS   = 4,
  parameter int COLS   = 16,
  parameter int ADDR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  life_step_engine_if.master  bus
);
  localparam int CNT_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_sel;
  logic [COLS-1:0]   r_buf [ROWS];
  logic [15:0]       r_gen;
  logic              r_stable;
  logic              r_extinct;
  logic [COLS-1:0]   w_next [ROWS];
  logic              w_same;
  logic              w_zero;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_cap_idx;

  function automatic logic [3:0] tri_cnt(input logic [COLS-1:0] row, input int c, input logic with_mid);
    return {3'b000, row[(c + COLS - 1) % COLS]} + {3'b000, row[(c + 1) % COLS]} +
           {3'b000, row[c] & with_mid};
  endfunction

  function automatic logic cell_next(input logic [COLS-1:0] up, input logic [COLS-1:0] mid,
                                     input logic [COLS-1:0] dn, input int c);
    logic [3:0] n;
    n = tri_cnt(up, c, 1'b1) + tri_cnt(mid, c, 1'b0) + tri_cnt(dn, c, 1'b1);
    return (n == 4'd3) || (mid[c] && (n == 4'd2));
  endfunction

  // Next generation depends only on the buffered old generation, never on the store.
  always_comb begin
    w_same = 1'b1;
    w_zero = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      w_next[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        w_next[r][c] = cell_next(r_buf[(r + ROWS - 1) % ROWS], r_buf[r], r_buf[(r + 1) % ROWS], c);
      end
      if (w_next[r] != r_buf[r]) w_same = 1'b0;
      if (w_next[r] != '0)       w_zero = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_READ;
      S_READ:  if (r_cnt == CNT_W'(ROWS)) w_state_nxt = S_WRITE;
      S_WRITE: if (r_sel == ADDR_W'(ROWS - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read data lags mem_sel by one cycle, so count c captures row c-1.
  assign w_cap_idx = ADDR_W'(r_cnt - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_gen     <= '0;
      r_stable  <= 1'b0;
      r_extinct <= 1'b0;
      for (int r = 0; r < ROWS; r++) r_buf[r] <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sel <= '0;
            r_cnt <= '0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt != '0) r_buf[w_cap_idx] <= bus.mem_rd_data;
          if (r_cnt == CNT_W'(ROWS))          r_sel <= '0;
          else if (r_cnt < CNT_W'(ROWS - 1))  r_sel <= r_sel + 1'b1;
        end
        S_WRITE: begin
          if (r_sel == ADDR_W'(ROWS - 1)) begin
            r_stable  <= w_same;
            r_extinct <= w_zero;
            r_gen     <= r_gen + 16'd1;
          end else begin
            r_sel <= r_sel + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A reset landing mid-WRITE must not let the store commit the row at that same edge.
  assign w_wr_en         = (r_state == S_WRITE) && !rst;
  assign bus.mem_wr_en   = w_wr_en;
  assign bus.mem_wr_data = w_wr_en ? w_next[r_sel] : '0;
  assign bus.mem_sel     = r_sel;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.gen_count   = r_gen;
  assign bus.stable      = r_stable;
  assign bus.extinct     = r_extinct;
endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine: table of grids with hand-computed next generations,
// plus sequences for start handling, back-to-back steps and reset during write-back.
module tb_life_step_engine;
  localparam int ROWS   = 4;
  localparam int COLS   = 16;
  localparam int ADDR_W = 2;

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;
  typedef struct packed {
    grid_t gin;
    grid_t gout;
    logic  stb;
    logic  ext;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  life_step_engine_if #(.ADDR_W(ADDR_W), .COLS(COLS)) bus ();

  life_step_engine #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Grid store model: 1-cycle synchronous read, write on mem_wr_en, bench bulk load.
  logic [COLS-1:0] mem [ROWS];
  logic            ld_req;
  grid_t           ld_grid;
  always @(posedge clk) begin
    bus.mem_rd_data <= mem[bus.mem_sel];
    if (ld_req) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= ld_grid[i];
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_sel] <= bus.mem_wr_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int gen_exp = 0;
  logic [COLS-1:0] wr_log [ROWS];
  int lat, wr_cnt, order_err, rd_err, busy_err;
  vec_t vecs [5];

  function automatic grid_t mk(input logic [15:0] r0, input logic [15:0] r1,
                               input logic [15:0] r2, input logic [15:0] r3);
    grid_t g;
    g[0] = r0; g[1] = r1; g[2] = r2; g[3] = r3;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input grid_t g);
    @(negedge clk);
    ld_grid = g;
    ld_req  = 1'b1;
    @(negedge clk);
    ld_req  = 1'b0;
  endtask

  // One step; returns at the negedge where done is seen (or after the cycle budget).
  task automatic run_step();
    for (int i = 0; i < ROWS; i++) wr_log[i] = 'x;
    wr_cnt = 0; order_err = 0; rd_err = 0; busy_err = 0; lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n <= ROWS && bus.mem_sel !== ADDR_W'(n - 1)) rd_err++;
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.mem_wr_en === 1'b1) begin
        if (bus.mem_sel !== ADDR_W'(wr_cnt)) order_err++;
        if (!$isunknown(bus.mem_sel)) wr_log[bus.mem_sel] = bus.mem_wr_data;
        wr_cnt++;
      end
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_step(input string tag, input grid_t exp_g, input logic stb, input logic ext);
    gen_exp++;
    check({tag, " latency"}, lat, 10);
    check({tag, " wr_count"}, wr_cnt, ROWS);
    check({tag, " wr_order"}, order_err, 0);
    check({tag, " rd_order"}, rd_err, 0);
    check({tag, " busy"}, busy_err, 0);
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s row%0d", tag, r), wr_log[r], exp_g[r]);
    check({tag, " gen_count"}, bus.gen_count, 32'(gen_exp));
    check({tag, " stable"}, bus.stable, stb);
    check({tag, " extinct"}, bus.extinct, ext);
    @(negedge clk);
    check({tag, " idle_after"}, {bus.busy, bus.done, bus.mem_wr_en}, 0);
  endtask

  initial begin
    int dones;
    rst       = 1'b1;
    bus.start = 1'b0;
    ld_req    = 1'b0;
    ld_grid   = '0;

    vecs[0] = '{mk(16'h0000, 16'h8003, 16'h0000, 16'h0000), mk(16'h0001, 16'h0001, 16'h0001, 16'h0000), 1'b0, 1'b0};
    vecs[1] = '{mk(16'h0000, 16'h0006, 16'h0006, 16'h0000), mk(16'h0000, 16'h0006, 16'h0006, 16'h0000), 1'b1, 1'b0};
    vecs[2] = '{mk(16'h0000, 16'h0100, 16'h0000, 16'h0000), mk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0, 1'b1};
    vecs[3] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), mk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0, 1'b1};
    vecs[4] = '{mk(16'h0000, 16'hFFFF, 16'h0000, 16'h0000), mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000), 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset wr_en", bus.mem_wr_en, 0);
    check("reset sel", bus.mem_sel, 0);
    check("reset wr_data", bus.mem_wr_data, 0);
    check("reset gen_count", bus.gen_count, 0);
    check("reset flags", {bus.stable, bus.extinct}, 0);

    // Blinker: two steps with the second running on what the first wrote back.
    load(mk(16'h0000, 16'h0038, 16'h0000, 16'h0000));
    run_step();
    check_step("blinker1", mk(16'h0010, 16'h0010, 16'h0010, 16'h0000), 1'b0, 1'b0);
    run_step();
    check_step("blinker2", mk(16'h0000, 16'h0038, 16'h0000, 16'h0000), 1'b0, 1'b0);

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].gin);
      run_step();
      check_step($sformatf("vec%0d", v), vecs[v].gout, vecs[v].stb, vecs[v].ext);
    end

    // start held high: a new step begins on each IDLE visit (11-cycle period).
    load(mk(16'h0000, 16'h0038, 16'h0000, 16'h0000));
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (n == 25) bus.start = 1'b0;
    end
    gen_exp += 3;
    check("held dones", dones, 3);
    check("held gen_count", bus.gen_count, 32'(gen_exp));
    check("held busy_end", bus.busy, 0);
    check("held mem0", mem[0], 16'h0010);
    check("held mem1", mem[1], 16'h0010);

    // start pulsed again while busy must be ignored.
    load(mk(16'h0000, 16'h0000, 16'h0000, 16'h0000));
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      bus.start = (n == 3);
      if (bus.done === 1'b1) dones++;
    end
    gen_exp += 1;
    check("pulse dones", dones, 1);
    check("pulse gen_count", bus.gen_count, 32'(gen_exp));
    check("pulse flags", {bus.stable, bus.extinct}, 2'b11);

    // Reset after row 1 is written back: rows 2..3 keep the old generation.
    load(mk(16'h0000, 16'h0038, 16'h0000, 16'h0000));
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst wr_en", bus.mem_wr_en, 0);
    check("rst sel", bus.mem_sel, 0);
    check("rst gen_count", bus.gen_count, 0);
    check("rst flags", {bus.stable, bus.extinct}, 0);
    rst = 1'b0;
    check("rst mem0", mem[0], 16'h0010);
    check("rst mem1", mem[1], 16'h0010);
    check("rst mem2", mem[2], 16'h0000);
    check("rst mem3", mem[3], 16'h0000);
    gen_exp = 0;
    run_step();
    check_step("after_rst", mk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
